// File: rtl/window_pkg.sv
// Shared widths and types for the 3x3 window generator.
// A window row packs three pixels: [7:0]=left, [15:8]=centre, [23:16]=right.
package window_pkg;

  localparam int PIX_W = 8;
  localparam int ROW_W = 3 * PIX_W;

  typedef logic [ROW_W-1:0] win_row_t;

  // Newest pixel enters the right column; the old left column drops out.
  function automatic win_row_t shift_in(input win_row_t row, input logic [PIX_W-1:0] pix);
    return {pix, row[ROW_W-1:PIX_W]};
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-line delay: dout is the value written DEPTH enables earlier.
// Circular RAM addressed by one wrapping pointer (read before write at the same slot).
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;

  assign dout = mem_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  // NOTE: the RAM has no reset so it maps onto block/distributed memory;
  // stale contents are never observed because the counters mask rows 0/1.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

endmodule

// File: rtl/window_gen.sv
// Streaming 3x3 window generator: two line buffers feed three horizontal
// shift registers; a registered window is emitted for every interior centre.
module window_gen
  import window_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             sof,
  output win_row_t         win_out [0:2],
  output logic             win_valid,
  output logic             frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col_q, col_d, cur_col;
  logic [RW-1:0]    row_q, row_d, cur_row;
  logic [PIX_W-1:0] lb1_dout, lb2_dout;
  win_row_t         top_q, mid_q, bot_q;
  win_row_t         top_d, mid_d, bot_d;
  win_row_t         win_q [0:2];
  logic             win_valid_q, frame_done_q;
  logic             win_fire, at_last;

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_valid),
    .din  (pix_in),
    .dout (lb1_dout)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk  (clk),
    .rst  (rst),
    .en   (pix_valid),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_col  = sof ? '0 : col_q;
    cur_row  = sof ? '0 : row_q;
    win_fire = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    at_last  = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
    col_d    = col_q;
    row_d    = row_q;
    top_d    = top_q;
    mid_d    = mid_q;
    bot_d    = bot_q;
    if (pix_valid) begin
      top_d = shift_in(top_q, lb2_dout);
      mid_d = shift_in(mid_q, lb1_dout);
      bot_d = shift_in(bot_q, pix_in);
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      mid_q        <= '0;
      bot_q        <= '0;
      win_q        <= '{default: '0};
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      mid_q        <= mid_d;
      bot_q        <= bot_d;
      win_valid_q  <= win_fire;
      frame_done_q <= win_fire && at_last;
      if (win_fire) begin
        win_q[0] <= top_d;
        win_q[1] <= mid_d;
        win_q[2] <= bot_d;
      end
    end
  end

  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/window_gen.md
Name: window_gen

Overview:
- Streaming 3x3 window generator directly upstream of the convolution kernel stage.
- Accepts a raster-order 8-bit pixel stream, buffers two previous image lines, and presents each 3x3 neighbourhood as three packed 24-bit rows in the exact format the kernel consumes (cache_in[0:2]).
- Emits one window per accepted interior-centre pixel; no border padding.

Parameters:
- IMG_W, 256, pixels per line (>=3)
- IMG_H, 256, lines per frame (>=3)
- PIX_W, 8, pixel width in bits (fixed at 8 for kernel compatibility)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- pix_valid  in  1  pix_in valid this cycle; no backpressure
- pix_in  in  8  pixel, raster order (left->right, top->bottom)
- sof  in  1  start of frame; qualified by pix_valid
- win_out  out  [23:0] x [0:2]  3x3 window: [0]=top row, [2]=bottom row; per row [7:0]=left col, [15:8]=centre, [23:16]=right col
- win_valid  out  1  win_out holds a new window this cycle (1-cycle pulse)
- frame_done  out  1  1-cycle pulse with output for the last pixel of the frame

Behaviour:
- Reset: col/row counters=0, win_out all 0, win_valid=0, frame_done=0. Line-buffer RAM contents are not reset; they are masked by the counters.
- Accept: pixel taken when pix_valid=1. Nothing advances when pix_valid=0; gaps are allowed anywhere.
- Counters: col 0..IMG_W-1. At col=IMG_W-1, col->0 and row++. At (IMG_H-1, IMG_W-1), both counters -> 0.
- Line buffers: two IMG_W-deep delay lines, each advanced only on accept.
  - lb1 output = pixel one line above the incoming pixel.
  - lb2 (fed by lb1 output) = pixel two lines above.
- Shift windows: three 3-pixel horizontal shift registers (top=lb2 tap, mid=lb1 tap, bottom=pix_in), shifted on accept. The newest pixel enters the right column, [23:16].
- Valid window: an accept at (row>=2, col>=2) produces window_valid. The window is centred on (row-1, col-1).
- Output timing: registered; win_out/win_valid update on the clock edge after the accept, i.e. latency 1 cycle.
- Output hold: win_out holds its value when win_valid=0.
- Window count: exactly (IMG_W-2)*(IMG_H-2) valid windows per frame. Columns 0/1 after a line wrap never produce a window, so stale left-column data never leaks across lines.
- sof:
  - sof=1 with pix_valid=1: that pixel is (0,0); counters are forced to restart regardless of prior position.
  - Partial frame is abandoned; no frame_done for it.
  - sof=1 with pix_valid=0 is ignored.
  - sof is not required; frames follow back-to-back by counter wrap.
- frame_done: registered alongside the win_valid for pixel (IMG_H-1, IMG_W-1); both are 1 in the same cycle.
- Reset mid-frame: all state per reset values; the next accepted pixel is (0,0).

Decomposition:
- Package window_pkg: PIX_W, ROW_W = 3*PIX_W, and typedef win_row_t = logic [ROW_W-1:0].
- Sub-module line_buffer: params DEPTH, WIDTH; ports clk, rst, en, din, dout.
  - Circular RAM with one wrapping pointer.
  - dout = value written DEPTH enables earlier.
  - Instantiated twice (lb1, lb2).
- Top level: counters, shift registers, output regs.

Test Plan (IMG_W=5, IMG_H=4, pixel = row*16+col, sof on first pixel):
- Continuous stream: first win_valid one cycle after accepting (2,2), with win_out[0]=0x020100, [1]=0x121110, [2]=0x222120. Next window [2]=0x232221. Exactly 6 windows total.
- Line-wrap check: no win_valid after accepting (3,0) or (3,1). The window after (3,2) has [0]=0x121110, [1]=0x222120, [2]=0x323130.
- Random pix_valid gaps (~50% duty): identical window sequence and values to the continuous case; win_out is stable during gaps.
- Frame end/back-to-back: frame_done=1 together with the window [2]=0x343332. A second frame without sof reproduces the identical 6 windows.
- sof mid-frame: sof asserted at (2,3) restarts the frame. No window until the new (2,2), and no frame_done for the abandoned frame.
- rst asserted mid-frame (after (2,3)): outputs go to 0 the next cycle. A fresh stream after release yields the same first window as scenario 1.
